// File: rtl/segdisp_signed.sv
// Signed-decimal 7-segment driver: sequential shift-add-3 conversion, leading-zero
// blanking with minus sign, and a free-running digit multiplexer.
module segdisp_signed #(
    parameter int DIGITS      = 4,
    parameter int IN_WIDTH    = 12,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [IN_WIDTH-1:0] in_data,
    output logic                in_ready,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic                overflow
);

    // Handshake: a value transfers on any rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE and in_data must be held until that edge.

    localparam int BW = DIGITS * 4;
    localparam int SW = $clog2(IN_WIDTH);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    localparam logic [SW-1:0] STEP_LAST = SW'(IN_WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    localparam logic [6:0] GLYPH_MINUS = 7'b1000000;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) r = r * 32'd10;
        return r;
    endfunction

    // Largest magnitudes that fit; a negative value gives up one digit to the sign.
    localparam logic [31:0] POS_MAX = pow10(DIGITS) - 32'd1;
    localparam logic [31:0] NEG_MAX = pow10(DIGITS - 1) - 32'd1;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b0111111;
            4'd1:    g = 7'b0000110;
            4'd2:    g = 7'b1011011;
            4'd3:    g = 7'b1001111;
            4'd4:    g = 7'b1100110;
            4'd5:    g = 7'b1101101;
            4'd6:    g = 7'b1111100;
            4'd7:    g = 7'b0000111;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1100111;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic                neg_r;
    logic                ovf_r;
    logic [IN_WIDTH-1:0] mag_r;
    logic [BW-1:0]       bcd_r;
    logic [SW-1:0]       step_r;
    logic [6:0]          disp_r [DIGITS];
    logic [CW-1:0]       cnt_r;
    logic [IW-1:0]       idx_r;

    logic                accept;
    logic                in_neg;
    logic [IN_WIDTH-1:0] in_mag;
    logic [31:0]         in_mag_ext;
    logic                in_ovf;
    logic [BW-1:0]       bcd_adj;
    logic [BW-1:0]       bcd_step;
    logic [6:0]          disp_new [DIGITS];
    int                  msd;
    logic                cnt_wrap;
    logic [IW-1:0]       idx_next;
    logic [DIGITS-1:0]   an_next;
    logic [6:0]          seg_next;

    assign in_ready   = (state == IDLE);
    assign accept     = in_valid && (state == IDLE);
    assign in_neg     = in_data[IN_WIDTH-1];
    assign in_mag     = in_neg ? (~in_data + IN_WIDTH'(1)) : in_data;
    assign in_mag_ext = 32'(in_mag);
    assign in_ovf     = in_neg ? (in_mag_ext > NEG_MAX) : (in_mag_ext > POS_MAX);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CONVERT;
            CONVERT: if (step_r == STEP_LAST) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One shift-add-3 step: correct every nibble >= 5, then shift in the next magnitude bit.
    always_comb begin
        bcd_adj = bcd_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_r[i*4 +: 4] + 4'd3;
        end
        bcd_step = BW'({bcd_adj, mag_r[IN_WIDTH-1]});
    end

    // Compose glyphs from the finished BCD value; msd stays 0 for a zero value.
    always_comb begin
        msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[i*4 +: 4] != 4'd0) msd = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_r)                     disp_new[i] = GLYPH_MINUS;
            else if (i <= msd)             disp_new[i] = glyph(bcd_r[i*4 +: 4]);
            else if (neg_r && i == msd + 1) disp_new[i] = GLYPH_MINUS;
            else                           disp_new[i] = GLYPH_BLANK;
        end
    end

    always_comb begin
        cnt_wrap = (cnt_r == CNT_LAST);
        idx_next = idx_r;
        if (cnt_wrap) idx_next = (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
        an_next = '0;
        an_next[idx_next] = 1'b1;
        // During COMMIT the fresh glyphs bypass the display registers so the new
        // value reaches seg in the same cycle the registers load.
        seg_next = (state == COMMIT) ? disp_new[idx_next] : disp_r[idx_next];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            neg_r    <= 1'b0;
            ovf_r    <= 1'b0;
            mag_r    <= '0;
            bcd_r    <= '0;
            step_r   <= '0;
            for (int i = 0; i < DIGITS; i++) disp_r[i] <= GLYPH_BLANK;
            cnt_r    <= '0;
            idx_r    <= '0;
            seg      <= GLYPH_BLANK;
            an       <= DIGITS'(1);
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            cnt_r <= cnt_wrap ? '0 : cnt_r + CW'(1);
            idx_r <= idx_next;
            seg   <= seg_next;
            an    <= an_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        neg_r  <= in_neg;
                        ovf_r  <= in_ovf;
                        mag_r  <= in_mag;
                        bcd_r  <= '0;
                        step_r <= '0;
                    end
                end
                CONVERT: begin
                    bcd_r  <= bcd_step;
                    mag_r  <= {mag_r[IN_WIDTH-2:0], 1'b0};
                    step_r <= step_r + SW'(1);
                end
                COMMIT: begin
                    for (int i = 0; i < DIGITS; i++) disp_r[i] <= disp_new[i];
                    overflow <= ovf_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_segdisp_signed.sv
// Bench for segdisp_signed: table vectors, random values against a decimal model,
// and hand-written handshake and reset sequences.
module tb_segdisp_signed;

    localparam int DIGITS      = 4;
    localparam int IN_WIDTH    = 12;
    localparam int REFRESH_DIV = 4;
    localparam int EW          = 1 + 7 * DIGITS;
    localparam int LAT         = IN_WIDTH + 2;

    localparam logic [6:0] G0 = 7'b0111111, G1 = 7'b0000110, G2 = 7'b1011011;
    localparam logic [6:0] G3 = 7'b1001111, G4 = 7'b1100110, G5 = 7'b1101101;
    localparam logic [6:0] G7 = 7'b0000111, G9 = 7'b1100111;
    localparam logic [6:0] MI = 7'b1000000, BL = 7'b0000000;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic [IN_WIDTH-1:0] in_data = '0;
    logic                in_ready;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                overflow;

    segdisp_signed #(.DIGITS(DIGITS), .IN_WIDTH(IN_WIDTH), .REFRESH_DIV(REFRESH_DIV)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .seg(seg), .an(an), .overflow(overflow)
    );

    // Clock and reset-relative cycle count used for the expected digit select.
    always #5 clk = ~clk;
    int k;
    always @(posedge clk) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    int total = 0;
    int bad = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        int            value;
        logic [EW-1:0] exp;
    } vec_t;
    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [6:0] digit_glyph(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111100;
            7: return 7'b0000111;
            8: return 7'b1111111;
            default: return 7'b1100111;
        endcase
    endfunction

    // Decimal reference: {overflow, digit3 .. digit0 glyphs}.
    function automatic logic [EW-1:0] model(input int v);
        logic [EW-1:0] r;
        int  m, n, t, pw;
        bit  neg;
        neg = (v < 0);
        m   = neg ? -v : v;
        r   = '0;
        if ((!neg && m > 9999) || (neg && m > 999)) begin
            r[EW-1] = 1'b1;
            for (int i = 0; i < DIGITS; i++) r[i*7 +: 7] = MI;
        end else begin
            n = 1;
            t = m / 10;
            while (t > 0) begin
                n++;
                t = t / 10;
            end
            pw = 1;
            for (int i = 0; i < DIGITS; i++) begin
                if (i < n)                r[i*7 +: 7] = digit_glyph((m / pw) % 10);
                else if (neg && i == n)   r[i*7 +: 7] = MI;
                else                      r[i*7 +: 7] = BL;
                pw = pw * 10;
            end
        end
        return r;
    endfunction

    task automatic check_display(input logic [EW-1:0] e, input string name, input int cycles);
        int d;
        for (int c = 0; c < cycles; c++) begin
            d = (k / REFRESH_DIV) % DIGITS;
            check({name, "_an"}, 32'(an), 32'(1 << d));
            check({name, "_seg"}, 32'(seg), 32'(e[d*7 +: 7]));
            check({name, "_ovf"}, 32'(overflow), 32'(e[EW-1]));
            tick();
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic load_and_check(input int v, input logic [EW-1:0] e, input string name);
        wait_ready();
        in_valid = 1'b1;
        in_data  = IN_WIDTH'(v);
        exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
        for (int j = 1; j < LAT; j++) begin
            check({name, "_busy"}, 32'(in_ready), 32'd0);
            tick();
        end
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        check_display(exp_q.pop_front(), name, DIGITS * REFRESH_DIV);
    endtask

    initial begin
        logic [EW-1:0] blank_exp, e5;
        int v, d;
        blank_exp = '0;

        vecs[0] = '{1234,  {1'b0, G1, G2, G3, G4}};
        vecs[1] = '{-42,   {1'b0, BL, MI, G4, G2}};
        vecs[2] = '{0,     {1'b0, BL, BL, BL, G0}};
        vecs[3] = '{2047,  {1'b0, G2, G0, G4, G7}};
        vecs[4] = '{-2048, {1'b1, MI, MI, MI, MI}};
        vecs[5] = '{5,     {1'b0, BL, BL, BL, G5}};
        vecs[6] = '{-999,  {1'b0, MI, G9, G9, G9}};
        vecs[7] = '{-1000, {1'b1, MI, MI, MI, MI}};
        vecs[8] = '{100,   {1'b0, BL, G1, G0, G0}};
        vecs[9] = '{-1,    {1'b0, BL, BL, MI, G1}};

        // Reset state and idle digit rotation.
        tick();
        tick();
        check("rst_seg", 32'(seg), 32'd0);
        check("rst_an", 32'(an), 32'd1);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        check_display(blank_exp, "idle", 2 * DIGITS * REFRESH_DIV + 1);

        for (int i = 0; i < 10; i++) load_and_check(vecs[i].value, vecs[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 4095));
            if (v >= 2048) v = v - 4096;
            load_and_check(v, model(v), $sformatf("rnd%0d", i));
        end

        // Back-to-back: 5 then 7 with in_valid held high.
        wait_ready();
        e5 = model(5);
        in_valid = 1'b1;
        in_data  = IN_WIDTH'(5);
        tick();
        in_data = IN_WIDTH'(7);
        for (int j = 1; j < LAT; j++) begin
            check("b2b_busy1", 32'(in_ready), 32'd0);
            tick();
        end
        check("b2b_accept2", 32'(in_ready), 32'd1);
        d = (k / REFRESH_DIV) % DIGITS;
        check("b2b_seg5", 32'(seg), 32'(e5[d*7 +: 7]));
        tick();
        in_valid = 1'b0;
        for (int j = 1; j < LAT; j++) begin
            d = (k / REFRESH_DIV) % DIGITS;
            check("b2b_busy2", 32'(in_ready), 32'd0);
            check("b2b_hold5", 32'(seg), 32'(e5[d*7 +: 7]));
            tick();
        end
        check("b2b_ready2", 32'(in_ready), 32'd1);
        check_display(model(7), "b2b_7", DIGITS * REFRESH_DIV);

        // Reset at T+6 of a conversion of 999: no commit, outputs back to reset values.
        wait_ready();
        in_valid = 1'b1;
        in_data  = IN_WIDTH'(999);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_seg", 32'(seg), 32'd0);
        check("abort_an", 32'(an), 32'd1);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_ovf", 32'(overflow), 32'd0);
        check_display(blank_exp, "abort", 2 * LAT);

        // Reset wins over a simultaneous accept.
        load_and_check(-7, model(-7), "pre_prio");
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = IN_WIDTH'(123);
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("prio_ready", 32'(in_ready), 32'd1);
            tick();
        end
        check_display(blank_exp, "prio", LAT + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/segdisp_signed.md
# segdisp_signed

Parametrised, multiplexed signed-decimal display driver for a common-segment 7-segment bank. It accepts a two's-complement binary value over a valid/ready handshake and converts it to BCD sequentially (shift-add-3). It applies leading-zero blanking and a minus sign, then time-multiplexes the digits with a programmable refresh rate. It replaces per-digit combinational decoding at the top level, so result registers can drive a display directly.

## Interface
- DIGITS, 4: number of physical digits; legal 2..8.
- IN_WIDTH, 12: input width in bits, signed; legal 2..27.
- REFRESH_DIV, 50000: clock cycles each digit stays selected; legal ≥1.
- clk  input  1  sole clock; one clock domain for the whole block.
- reset  input  1  reset is synchronous and active-high.
- in_valid  input  1  in_data valid.
- in_data  input  IN_WIDTH  two's-complement value to display.
- in_ready  output  1  block can accept a value (high only in IDLE).
- seg  output  7  segment drive, bit order GFEDCBA, 1 = segment lit.
- an  output  DIGITS  one-hot digit select, 1 = digit on; an[0] = rightmost (least significant).
- overflow  output  1  the displayed value did not fit; stays valid until the next commit.

## Operation
- Handshake: a value is accepted in any cycle with in_valid && in_ready. in_valid is ignored while in_ready is low. Upstream must hold in_data until it is accepted.
- FSM states:
  - IDLE: in_ready=1. On accept, the block registers the sign and magnitude, then goes to CONVERT.
  - CONVERT: exactly IN_WIDTH shift-add-3 steps into a DIGITS×4-bit BCD register, then COMMIT.
  - COMMIT: display registers load, then IDLE.
  - There are no other transitions.
- Magnitude: |in_data| is held in IN_WIDTH unsigned bits, so the most negative input is exact (e.g. −2048 → 2048).
- Overflow check, made at accept against constants:
  - Positive or zero values overflow when magnitude > 10^DIGITS − 1.
  - Negative values overflow when magnitude > 10^(DIGITS−1) − 1, because the sign needs one digit.
  - On overflow, conversion still runs, so latency is fixed. COMMIT then loads minus on every digit and sets overflow=1. Otherwise COMMIT sets overflow=0.
- Digit composition at COMMIT:
  - Digits above the most significant non-zero BCD digit are blank.
  - Value 0 shows "0" on digit 0 only.
  - For a negative value, the minus sign goes on the digit immediately left of the most significant non-zero digit.
- Glyphs (GFEDCBA):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111100, 7=0000111, 8=1111111, 9=1100111
  - minus=1000000, blank=0000000
- Refresh:
  - The counter counts 0..REFRESH_DIV−1.
  - When it wraps, the digit index advances and wraps from DIGITS−1 to 0.
  - seg and an are registered together from the display registers and the index, so they always change in the same cycle.
  - Conversion never stalls or resets the refresh counter.

## Timing
- Reset values:
  - in_ready=1, seg=0000000, an=1 (digit 0), overflow=0.
  - All display registers blank, refresh counter 0, digit index 0, FSM IDLE.
- Accept in cycle T:
  - CONVERT runs T+1..T+IN_WIDTH.
  - COMMIT is at T+IN_WIDTH+1.
  - in_ready is low T+1..T+IN_WIDTH+1 and high again at T+IN_WIDTH+2.
  - seg shows the new value for the selected digit from T+IN_WIDTH+2.
  - The next accept is possible at T+IN_WIDTH+2.
- Latency accept→display: IN_WIDTH+2 cycles, independent of value and of overflow.
- an: the digit changes every REFRESH_DIV cycles. With REFRESH_DIV=1, the digit advances every cycle.
- Reset mid-conversion: the operation is aborted with no commit. All outputs take their reset values on the next cycle.
- Reset takes priority over a simultaneous accept. The value presented in that cycle is not accepted.

## Test plan
All scenarios use DIGITS=4, IN_WIDTH=12, REFRESH_DIV=4.
- Reset, then idle:
  - seg=0000000, an=0001, in_ready=1, overflow=0.
  - an goes 0001→0010→0100→1000→0001 every 4 cycles.
- Load 1234 at T:
  - in_ready is low T+1..T+13 and high at T+14.
  - Digits 3..0 show 0000110, 1011011, 1001111, 1100110; overflow=0.
- Load −42 (12'hFD6):
  - Digit 0 = 1011011, digit 1 = 1100110, digit 2 = 1000000, digit 3 = blank.
- Load 0, then 2047, then −2048:
  - 0: digit 0 = 0111111, others blank.
  - 2047: no overflow.
  - −2048: overflow=1, all digits 1000000.
  - Loading 5 afterwards clears overflow.
- Back-to-back 5 then 7 with in_valid held high:
  - The second value is accepted exactly at T+14.
  - 7 is displayed from T+28.
- Reset asserted at T+6 of a conversion of 999:
  - All outputs take their reset values at T+7, and no digits are lit.
  - in_ready=1 from T+7.
